sel_n_1_rr: RTL and testbench

//  - Parametrised N-to-1, W-bit channel selector with registered output and valid/ready handshake.
//  - Generalises the team's 4:1 2-bit gate-level selector: any channel count and width.
//  - Two modes: fixed select by SEL, or fair round-robin over requesting channels.
//  - Sits between N producer channels and one consumer; one output register stage, throughput 1 word/cycle.

---
 rtl/sel_pkg.sv | 12 +
 rtl/sel_n_1_rr_rr_arb.sv | 33 +++
 rtl/sel_n_1_rr.sv | 85 ++++++++
 tb/tb_sel_n_1_rr.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sel_pkg.sv
// Shared constants and helpers for the N:1 round-robin channel selector.
package sel_pkg;

  localparam logic SEL_MODE_FIXED = 1'b0;
  localparam logic SEL_MODE_RR    = 1'b1;

  // Channel-index width, never less than one bit.
  function automatic int unsigned sel_clog2(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sel_n_1_rr_rr_arb.sv
// Rotating-priority arbiter: first requester after i_last, wrapping modulo N.
module rr_arb
  import sel_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = sel_clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [SW-1:0] o_gnt_idx
);

  always_comb begin
    int unsigned idx;
    logic        found;
    o_gnt     = '0;
    o_gnt_idx = '0;
    found     = 1'b0;
    idx       = 0;
    // i_last is always < N, so a single subtraction implements the wrap.
    for (int unsigned k = 1; k <= N; k++) begin
      idx = 32'(i_last) + k;
      if (idx >= N) idx = idx - N;
      if (!found && i_req[SW'(idx)]) begin
        found             = 1'b1;
        o_gnt[SW'(idx)]   = 1'b1;
        o_gnt_idx         = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/sel_n_1_rr.sv
// N-to-1 W-bit channel selector, fixed or round-robin, with one registered
// output stage and valid/ready handshakes on both sides.
module sel_n_1_rr
  import sel_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_mode,
  input  logic [sel_clog2(N)-1:0]      i_sel,
  input  logic [N*W-1:0]               i_in_data,
  input  logic [N-1:0]                 i_in_valid,
  output logic [N-1:0]                 o_in_ready,
  output logic [W-1:0]                 o_out_data,
  output logic [sel_clog2(N)-1:0]      o_out_ch,
  output logic                         o_out_valid,
  input  logic                         i_out_ready
);

  localparam int unsigned SW = sel_clog2(N);

  logic [SW-1:0] r_last;
  logic [W-1:0]  r_out_data;
  logic [SW-1:0] r_out_ch;
  logic          r_out_valid;

  logic [N-1:0]  w_rr_gnt;
  logic [SW-1:0] w_rr_idx;
  logic [N-1:0]  w_fix_gnt;
  logic [N-1:0]  w_gnt;
  logic [SW-1:0] w_gnt_idx;
  logic          w_load;
  logic          w_xfer;
  logic [W-1:0]  w_data;

  rr_arb #(.N(N), .SW(SW)) u_rr_arb (
    .i_req     (i_in_valid),
    .i_last    (r_last),
    .o_gnt     (w_rr_gnt),
    .o_gnt_idx (w_rr_idx)
  );

  // Fixed-mode grant; an out-of-range select grants nothing.
  always_comb begin
    w_fix_gnt = '0;
    if (32'(i_sel) < N) w_fix_gnt[i_sel] = i_in_valid[i_sel];
  end

  assign w_gnt      = (i_mode == SEL_MODE_RR) ? w_rr_gnt : w_fix_gnt;
  assign w_gnt_idx  = (i_mode == SEL_MODE_RR) ? w_rr_idx : i_sel;
  assign w_load     = ~r_out_valid | i_out_ready;
  assign o_in_ready = w_gnt & {N{w_load & i_rst_n}};
  assign w_xfer     = |o_in_ready;

  // AND-OR data mux keyed by the granted index.
  always_comb begin
    w_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_data = w_data | (i_in_data[i*W +: W] & {W{w_gnt_idx == SW'(i)}});
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_last      <= SW'(N - 1);
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data;
      r_out_ch    <= w_gnt_idx;
      if (i_mode == SEL_MODE_RR) r_last <= w_gnt_idx;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_ch    = r_out_ch;
  assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_sel_n_1_rr.sv
// Bench for sel_n_1_rr: directed vector table (N=4,W=2), hand sequence (N=3,W=8)
// and randomized traffic on both instances against a behavioural model.
module tb_sel_n_1_rr;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // N=4, W=2 instance
  logic       r4_rst_n, r4_mode, r4_ordy;
  logic [1:0] r4_sel;
  logic [7:0] r4_data;
  logic [3:0] r4_valid;
  logic [3:0] w4_rdy;
  logic [1:0] w4_d, w4_ch;
  logic       w4_v;

  // N=3, W=8 instance
  logic        r3_rst_n, r3_mode, r3_ordy;
  logic [1:0]  r3_sel;
  logic [23:0] r3_data;
  logic [2:0]  r3_valid;
  logic [2:0]  w3_rdy;
  logic [7:0]  w3_d;
  logic [1:0]  w3_ch;
  logic        w3_v;

  sel_n_1_rr #(.N(4), .W(2)) dut4 (
    .i_clk(clk), .i_rst_n(r4_rst_n), .i_mode(r4_mode), .i_sel(r4_sel),
    .i_in_data(r4_data), .i_in_valid(r4_valid), .o_in_ready(w4_rdy),
    .o_out_data(w4_d), .o_out_ch(w4_ch), .o_out_valid(w4_v), .i_out_ready(r4_ordy)
  );

  sel_n_1_rr #(.N(3), .W(8)) dut3 (
    .i_clk(clk), .i_rst_n(r3_rst_n), .i_mode(r3_mode), .i_sel(r3_sel),
    .i_in_data(r3_data), .i_in_valid(r3_valid), .o_in_ready(w3_rdy),
    .o_out_data(w3_d), .o_out_ch(w3_ch), .o_out_valid(w3_v), .i_out_ready(r3_ordy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic       rst_n, mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_v;
    logic [1:0] e_ch, e_d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rs, logic md, logic [1:0] sl, logic [3:0] vl, logic od,
                              logic [3:0] er, logic ev, logic [1:0] ec, logic [1:0] ed);
    vec_t v;
    v.rst_n = rs; v.mode = md; v.sel = sl; v.valid = vl; v.ordy = od;
    v.e_rdy = er; v.e_v = ev; v.e_ch = ec; v.e_d = ed;
    return v;
  endfunction

  // Drive dut3 for one cycle and check ready (mid-cycle) and outputs (after edge).
  task automatic step3(input logic rs, md, input logic [1:0] sl, input logic [2:0] vl,
                       input logic od, input logic [2:0] er, input logic ev,
                       input logic [1:0] ec, input logic [7:0] ed, input string nm);
    r3_rst_n = rs; r3_mode = md; r3_sel = sl; r3_valid = vl; r3_ordy = od;
    #4;
    chk({nm, ".rdy"}, 32'(w3_rdy), 32'(er));
    @(posedge clk); #1;
    chk({nm, ".v"}, 32'(w3_v), 32'(ev));
    chk({nm, ".ch"}, 32'(w3_ch), 32'(ec));
    chk({nm, ".d"}, 32'(w3_d), 32'(ed));
  endtask

  // Behavioural model, one slot per instance (0: N=4, 1: N=3).
  int m_v[2], m_ch[2], m_last[2], m_d[2];

  function automatic int model_grant(int d, int n, int mode, int sel, int valid);
    if (mode == 0) return (sel < n && ((valid >> sel) & 1) == 1) ? sel : -1;
    for (int k = 1; k <= n; k++) begin
      int c;
      c = (m_last[d] + k) % n;
      if (((valid >> c) & 1) == 1) return c;
    end
    return -1;
  endfunction

  task automatic rand_run(input int d, input int cycles);
    int n, w, rs, md, sl, vl, od, g, e_rdy;
    int cd[4];
    n = (d == 0) ? 4 : 3;
    w = (d == 0) ? 2 : 8;
    for (int t = 0; t < cycles; t++) begin
      rs = (t == 0 || $urandom_range(39) == 0) ? 0 : 1;
      md = int'($urandom_range(1));
      sl = int'($urandom_range(3));
      vl = int'($urandom_range((1 << n) - 1));
      od = ($urandom_range(3) != 0) ? 1 : 0;
      for (int i = 0; i < 4; i++) cd[i] = int'($urandom_range((1 << w) - 1));
      if (d == 0) begin
        r4_rst_n = rs[0]; r4_mode = md[0]; r4_sel = sl[1:0]; r4_valid = vl[3:0]; r4_ordy = od[0];
        r4_data = {cd[3][1:0], cd[2][1:0], cd[1][1:0], cd[0][1:0]};
      end else begin
        r3_rst_n = rs[0]; r3_mode = md[0]; r3_sel = sl[1:0]; r3_valid = vl[2:0]; r3_ordy = od[0];
        r3_data = {cd[2][7:0], cd[1][7:0], cd[0][7:0]};
      end
      g = model_grant(d, n, md, sl, vl);
      e_rdy = (rs == 1 && (m_v[d] == 0 || od == 1) && g >= 0) ? (1 << g) : 0;
      #4;
      chk($sformatf("rand%0d.rdy", d), (d == 0) ? 32'(w4_rdy) : 32'(w3_rdy), 32'(e_rdy));
      if (rs == 0) begin
        m_v[d] = 0; m_d[d] = 0; m_ch[d] = 0; m_last[d] = n - 1;
      end else if (e_rdy != 0) begin
        m_v[d] = 1; m_d[d] = cd[g]; m_ch[d] = g;
        if (md == 1) m_last[d] = g;
      end else if (od == 1) begin
        m_v[d] = 0;
      end
      @(posedge clk); #1;
      chk($sformatf("rand%0d.v", d),  (d == 0) ? 32'(w4_v)  : 32'(w3_v),  32'(m_v[d]));
      chk($sformatf("rand%0d.ch", d), (d == 0) ? 32'(w4_ch) : 32'(w3_ch), 32'(m_ch[d]));
      chk($sformatf("rand%0d.d", d),  (d == 0) ? 32'(w4_d)  : 32'(w3_d),  32'(m_d[d]));
    end
  endtask

  initial begin
    r4_rst_n = 1'b0; r4_mode = 1'b0; r4_sel = '0; r4_data = 8'he4; r4_valid = '0; r4_ordy = 1'b1;
    r3_rst_n = 1'b0; r3_mode = 1'b0; r3_sel = '0; r3_data = 24'h332211; r3_valid = '0; r3_ordy = 1'b1;

    // Reset with all channels requesting
    tbl.push_back(mk(0,0,0,4'hF,1, 4'h0,0,0,0));
    tbl.push_back(mk(0,0,0,4'hF,1, 4'h0,0,0,0));
    // Fixed select 2 then 3
    tbl.push_back(mk(1,0,2,4'hF,1, 4'h4,1,2,2));
    tbl.push_back(mk(1,0,3,4'hF,1, 4'h8,1,3,3));
    // Round-robin, all requesting; LAST still N-1 from reset
    tbl.push_back(mk(1,1,0,4'hF,1, 4'h1,1,0,0));
    tbl.push_back(mk(1,1,0,4'hF,1, 4'h2,1,1,1));
    tbl.push_back(mk(1,1,0,4'hF,1, 4'h4,1,2,2));
    tbl.push_back(mk(1,1,0,4'hF,1, 4'h8,1,3,3));
    tbl.push_back(mk(1,1,0,4'hF,1, 4'h1,1,0,0));
    tbl.push_back(mk(1,1,0,4'hF,1, 4'h2,1,1,1));
    // Reset back to LAST=3, then skip pattern 1010
    tbl.push_back(mk(0,1,0,4'hF,1, 4'h0,0,0,0));
    tbl.push_back(mk(1,1,0,4'hA,1, 4'h2,1,1,1));
    tbl.push_back(mk(1,1,0,4'hA,1, 4'h8,1,3,3));
    tbl.push_back(mk(1,1,0,4'hA,1, 4'h2,1,1,1));
    tbl.push_back(mk(1,1,0,4'hA,1, 4'h8,1,3,3));
    tbl.push_back(mk(1,1,0,4'h1,1, 4'h1,1,0,0));
    tbl.push_back(mk(1,1,0,4'h1,1, 4'h1,1,0,0));
    // Backpressure: hold ch1 three cycles, release streams ch2 with no bubble
    tbl.push_back(mk(1,1,0,4'h2,1, 4'h2,1,1,1));
    tbl.push_back(mk(1,1,0,4'h6,0, 4'h0,1,1,1));
    tbl.push_back(mk(1,1,0,4'h6,0, 4'h0,1,1,1));
    tbl.push_back(mk(1,1,0,4'h6,0, 4'h0,1,1,1));
    tbl.push_back(mk(1,1,0,4'h6,1, 4'h4,1,2,2));
    // Drain: valid falls, data/ch stay stale
    tbl.push_back(mk(1,1,0,4'h0,1, 4'h0,0,2,2));
    tbl.push_back(mk(1,1,0,4'h0,0, 4'h0,0,2,2));
    // Fixed select on an idle channel
    tbl.push_back(mk(1,0,1,4'hD,1, 4'h0,0,2,2));

    @(posedge clk); #1;
    foreach (tbl[i]) begin
      r4_rst_n = tbl[i].rst_n; r4_mode = tbl[i].mode; r4_sel = tbl[i].sel;
      r4_valid = tbl[i].valid; r4_ordy = tbl[i].ordy;
      #4;
      chk($sformatf("vec%0d.rdy", i), 32'(w4_rdy), 32'(tbl[i].e_rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d.v", i),  32'(w4_v),  32'(tbl[i].e_v));
      chk($sformatf("vec%0d.ch", i), 32'(w4_ch), 32'(tbl[i].e_ch));
      chk($sformatf("vec%0d.d", i),  32'(w4_d),  32'(tbl[i].e_d));
    end

    // N=3: reset mid-transfer drops the word and restores LAST=2
    step3(0,1,0,3'h7,1, 3'h0,0,0,8'h00, "n3_rst");
    step3(1,1,0,3'h7,0, 3'h1,1,0,8'h11, "n3_load");
    step3(1,1,0,3'h7,0, 3'h0,1,0,8'h11, "n3_hold");
    step3(0,1,0,3'h7,0, 3'h0,0,0,8'h00, "n3_midrst");
    step3(1,1,0,3'h7,1, 3'h1,1,0,8'h11, "n3_rr0");
    step3(1,1,0,3'h7,1, 3'h2,1,1,8'h22, "n3_rr1");
    step3(1,1,0,3'h7,1, 3'h4,1,2,8'h33, "n3_rr2");
    step3(1,1,0,3'h7,1, 3'h1,1,0,8'h11, "n3_rr3");
    step3(1,0,3,3'h7,1, 3'h0,0,0,8'h11, "n3_sel3");

    rand_run(0, 400);
    rand_run(1, 400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
